prng_xorshift_stream: RTL and testbench

//   Parametrised xorshift PRNG that generates one word per step, for any WIDTH.

---
 rtl/prng_xorshift_stream.sv | 201 ++++++++++++++++++++
 tb/tb_prng_xorshift_stream.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_xorshift_stream.sv
// -----------------------------------------------------------------------------
// prng_xorshift_stream
//
// Parametrised xorshift pseudo-random generator. Each step produces one WIDTH-bit
// word and offers it on a valid/ready output stream. It supports:
//   - seed loading, where a zero seed is replaced by SEED_DEFAULT
//   - a warm-up phase that discards WARMUP steps after every seed
//   - backpressure, so no word is skipped or lost while the consumer stalls
//   - a counter of accepted words
//
// Step function:
//   next(x): t = x ^ (x << SH_A); t = t ^ (t >> SH_B); t = t ^ (t << SH_C)
//   Every shift result is truncated to WIDTH bits.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      step enable; low pauses generation
//   seed_load  in   1      one-cycle strobe that loads seed_data (top priority)
//   seed_data  in   WIDTH  seed value; zero selects SEED_DEFAULT
//   rnd_data   out  WIDTH  registered output word
//   rnd_valid  out  1      rnd_data holds an unconsumed word
//   rnd_ready  in   1      consumer accepts the word when rnd_valid && rnd_ready
//   busy       out  1      high exactly while the FSM is in WARM
//   word_cnt   out  CNT_W  number of accepted words; wraps; cleared on seed
//   fsm_state  out  2      current FSM state (0 = IDLE, 1 = WARM, 2 = RUN)
//
// Handshake:
//   A word transfers on a rising edge where rnd_valid && rnd_ready. Once
//   rnd_valid is high, rnd_data and rnd_valid stay unchanged until the word
//   transfers or a seed load drops it. rnd_valid never depends
//   combinationally on rnd_ready.
// -----------------------------------------------------------------------------
module prng_xorshift_stream #(
    parameter int                WIDTH        = 8,
    parameter int                SH_A         = 3,
    parameter int                SH_B         = 5,
    parameter int                SH_C         = 4,
    parameter logic [WIDTH-1:0]  SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int                WARMUP       = 2,
    parameter int                CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_data,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // The warm-up counter only counts 0 .. WARMUP-1. Keep it at least one bit
    // wide so that WARMUP of 0 or 1 still elaborates cleanly.
    localparam int             WCW       = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? (WARMUP - 1) : 0);

    // After a seed, the FSM either warms up or starts producing immediately.
    localparam state_t SEED_TARGET = (WARMUP == 0) ? S_RUN : S_WARM;

    function automatic logic [WIDTH-1:0] xs_next(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] t;
        t = x ^ (x << SH_A);
        t = t ^ (t >> SH_B);
        t = t ^ (t << SH_C);
        return t;
    endfunction

    // Registered state
    state_t           fsm_q,   fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] wcnt_q,  wcnt_d;
    logic [WCW-1:0]   cnt_q,   cnt_d;

    // Combinational helpers
    logic [WIDTH-1:0] seed_val;
    logic [WIDTH-1:0] stepped;
    logic             accept;
    logic             run_step;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wcnt_d   = wcnt_q;
        cnt_d    = cnt_q;

        seed_val = (seed_data == '0) ? SEED_DEFAULT : seed_data;
        stepped  = xs_next(state_q);
        accept   = valid_q && rnd_ready;
        // Only step when the output register is free or is draining this
        // cycle. This keeps a stalled word and the generator state together.
        run_step = en && (!valid_q || rnd_ready);

        if (seed_load) begin
            // Seeding overrides everything, including a word in mid-handshake.
            // The pending word is dropped. rnd_data keeps its old value but is
            // no longer valid.
            state_d = seed_val;
            valid_d = 1'b0;
            wcnt_d  = '0;
            cnt_d   = '0;
            fsm_d   = SEED_TARGET;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    if (en) begin
                        // Auto-start: seed with the default value.
                        state_d = SEED_DEFAULT;
                        cnt_d   = '0;
                        fsm_d   = SEED_TARGET;
                    end
                end

                S_WARM: begin
                    if (en) begin
                        state_d = stepped;
                        if (cnt_q == WARM_LAST) begin
                            fsm_d = S_RUN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (accept) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                    if (run_step) begin
                        state_d = stepped;
                        data_d  = stepped;
                        valid_d = 1'b1;
                    end else if (accept) begin
                        // Word consumed while paused: nothing replaces it.
                        valid_d = 1'b0;
                    end
                end

                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rnd_data  = data_q;
    assign rnd_valid = valid_q;
    assign word_cnt  = wcnt_q;
    assign busy      = (fsm_q == S_WARM);
    assign fsm_state = fsm_q;

endmodule

// File: tb/tb_prng_xorshift_stream.sv
module tb_prng_xorshift_stream;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       rst_n;
  logic       en;
  logic       seed_load;
  logic [7:0] seed_data;
  logic       rnd_ready;

  logic [7:0]  rnd_data,  rnd_data0;
  logic        rnd_valid, rnd_valid0;
  logic        busy,      busy0;
  logic [15:0] word_cnt,  word_cnt0;
  logic [1:0]  fsm_state, fsm_state0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  prng_xorshift_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .busy      (busy),
    .word_cnt  (word_cnt),
    .fsm_state (fsm_state)
  );

  // Second instance without warm-up; it shares the stimulus.
  prng_xorshift_stream #(.WARMUP(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .rnd_data  (rnd_data0),
    .rnd_valid (rnd_valid0),
    .rnd_ready (rnd_ready),
    .busy      (busy0),
    .word_cnt  (word_cnt0),
    .fsm_state (fsm_state0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks;
  int failures;
  logic [7:0] exp_q[$];

  // Reference step. Shifts are written as multiplication and division, with a
  // modulo to truncate each result to 8 bits.
  function automatic logic [7:0] ref_next(input logic [7:0] x);
    int unsigned t;
    t = int'(x);
    t = t ^ ((t * 8) % 256);
    t = t ^ (t / 32);
    t = t ^ ((t * 16) % 256);
    return t[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic ld, input logic [7:0] sd, input logic r);
    en        = e;
    seed_load = ld;
    seed_data = sd;
    rnd_ready = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    check("rst_data",  {24'd0, rnd_data},  32'h0);
    check("rst_valid", {31'd0, rnd_valid}, 32'h0);
    check("rst_busy",  {31'd0, busy},      32'h0);
    check("rst_cnt",   {16'd0, word_cnt},  32'h0);
    check("rst_fsm",   {30'd0, fsm_state}, 32'h0);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs for one edge and the outputs expected after it
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        en;
    logic        ld;
    logic [7:0]  sd;
    logic        rdy;
    logic        e_valid;
    logic        e_busy;
    logic [7:0]  e_data;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [7:0]  x;
    logic [7:0]  prev_data;
    logic        stall_prev;
    logic [15:0] model_cnt;
    logic [7:0]  w0_exp[4];
    int          busy_cycles;
    int          n_accept;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Seed 0x01 followed by two warm-up steps (0x99, 0x63), then the stream
    // 0xF8, 0xA9, 0x86, 0x83, ...
    tbl[0]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hF8, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA9, 16'd1};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h86, 16'd2};
    for (int i = 6; i <= 10; i++)
      tbl[i] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h86, 16'd2};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h83, 16'd3};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h83, 16'd4};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h83, 16'd4};

    // T1 / T3 / T4: the table is run with seed 0x01, then with seed 0x00.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 14; i++) begin
        drive(tbl[i].en, tbl[i].ld, (pass == 0) ? tbl[i].sd : 8'h00, tbl[i].rdy);
        tick();
        check($sformatf("tbl%0d_r%0d_valid", pass, i), {31'd0, rnd_valid}, {31'd0, tbl[i].e_valid});
        check($sformatf("tbl%0d_r%0d_busy",  pass, i), {31'd0, busy},      {31'd0, tbl[i].e_busy});
        check($sformatf("tbl%0d_r%0d_data",  pass, i), {24'd0, rnd_data},  {24'd0, tbl[i].e_data});
        check($sformatf("tbl%0d_r%0d_cnt",   pass, i), {16'd0, word_cnt},  {16'd0, tbl[i].e_cnt});
      end
    end

    // T2: the WARMUP=0 instance streams immediately after the seed edge.
    do_reset();
    w0_exp[0] = 8'h99; w0_exp[1] = 8'h63; w0_exp[2] = 8'hF8; w0_exp[3] = 8'hA9;
    drive(1'b1, 1'b1, 8'h01, 1'b1);
    tick();
    check("w0_seed_valid", {31'd0, rnd_valid0}, 32'h0);
    check("w0_seed_busy",  {31'd0, busy0},      32'h0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("w0_data%0d", i),  {24'd0, rnd_data0},  {24'd0, w0_exp[i]});
      check($sformatf("w0_cnt%0d", i),   {16'd0, word_cnt0},  i);
      check($sformatf("w0_valid%0d", i), {31'd0, rnd_valid0}, 32'h1);
      check($sformatf("w0_busy%0d", i),  {31'd0, busy0},      32'h0);
    end

    // T5: auto-start from IDLE, with en low for 3 cycles during warm-up.
    do_reset();
    busy_cycles = 0;
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    busy_cycles += int'(busy);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      busy_cycles += int'(busy);
    end
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      busy_cycles += int'(busy);
    end
    check("auto_busy_cycles", busy_cycles, 32'd5);
    check("auto_busy_end",    {31'd0, busy}, 32'h0);
    tick();
    check("auto_first_valid", {31'd0, rnd_valid}, 32'h1);
    check("auto_first_data",  {24'd0, rnd_data},  32'hF8);

    // T6a: an asynchronous reset between edges clears outputs at once.
    tick();
    tick();
    check("pre_arst_cnt", {16'd0, word_cnt}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_data",  {24'd0, rnd_data},  32'h0);
    check("arst_valid", {31'd0, rnd_valid}, 32'h0);
    check("arst_busy",  {31'd0, busy},      32'h0);
    check("arst_cnt",   {16'd0, word_cnt},  32'h0);
    check("arst_fsm",   {30'd0, fsm_state}, 32'h0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();

    // T6b: a seed load during a stalled word drops the word, then the T1
    // timing starts again.
    drive(1'b1, 1'b1, 8'h01, 1'b1);
    tick();
    seed_load = 1'b0;
    tick();
    tick();
    tick();
    check("stall_pre_data", {24'd0, rnd_data}, 32'hF8);
    tick();
    check("stall_pre_cnt",  {16'd0, word_cnt}, 32'd1);
    rnd_ready = 1'b0;
    tick();
    check("stall_hold_data", {24'd0, rnd_data},  32'hA9);
    check("stall_hold_valid", {31'd0, rnd_valid}, 32'h1);
    seed_load = 1'b1;
    tick();
    check("reseed_valid", {31'd0, rnd_valid}, 32'h0);
    check("reseed_cnt",   {16'd0, word_cnt},  32'h0);
    check("reseed_busy",  {31'd0, busy},      32'h1);
    check("reseed_data",  {24'd0, rnd_data},  32'hA9);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    check("reseed_w1_busy", {31'd0, busy}, 32'h1);
    tick();
    check("reseed_w2_busy",  {31'd0, busy},      32'h0);
    check("reseed_w2_valid", {31'd0, rnd_valid}, 32'h0);
    tick();
    check("reseed_first_valid", {31'd0, rnd_valid}, 32'h1);
    check("reseed_first_data",  {24'd0, rnd_data},  32'hF8);

    // Randomised stream against a transaction-level model. After each seed
    // the first accepted word is next^(WARMUP+1)(seed), and each following
    // word is next() of the word before it.
    do_reset();
    stall_prev = 1'b0;
    prev_data  = 8'h00;
    model_cnt  = 16'd0;
    n_accept   = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) begin
        check("rnd_word_cnt", {16'd0, word_cnt}, {16'd0, model_cnt});
        check("rnd_busy_excl", {31'd0, busy && rnd_valid}, 32'h0);
        if (stall_prev) begin
          check("rnd_hold_valid", {31'd0, rnd_valid}, 32'h1);
          check("rnd_hold_data",  {24'd0, rnd_data},  {24'd0, prev_data});
        end
      end
      en        = ($urandom_range(0, 3) != 0);
      rnd_ready = ($urandom_range(0, 2) != 0);
      seed_load = (i == 0) || ($urandom_range(0, 60) == 0);
      seed_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (seed_load) begin
        x = (seed_data == 8'h00) ? 8'h01 : seed_data;
        for (int k = 0; k < 3; k++) x = ref_next(x);
        exp_q.delete();
        exp_q.push_back(x);
        model_cnt  = 16'd0;
        stall_prev = 1'b0;
      end else begin
        if (rnd_valid && rnd_ready) begin
          if (exp_q.size() == 0) begin
            check("rnd_queue_nonempty", 32'd0, 32'd1);
          end else begin
            x = exp_q.pop_front();
            check("rnd_word", {24'd0, rnd_data}, {24'd0, x});
            exp_q.push_back(ref_next(x));
          end
          model_cnt = model_cnt + 16'd1;
          n_accept++;
        end
        stall_prev = rnd_valid && !rnd_ready;
        prev_data  = rnd_data;
      end
      tick();
    end
    check("rnd_some_accepts", {31'd0, (n_accept > 100)}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
